// File: rtl/cfg_chain_loader_if.sv
// Bitstream word stream into the config chain loader; valid/ready, transfer on valid && ready.
interface cfg_chain_loader_if #(parameter int WORD_W = 32);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/cfg_chain_loader.sv
// Chain reset, then CHAIN_LEN bits MSB-first on a clk/2 config_clk; done 1+2*(RST_CYC+CHAIN_LEN) cycles after start.
// An empty bit source stalls config_clk low; word_ready drops while the holding buffer is full or all words are taken.
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 32,
  parameter int RST_CYC   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  cfg_chain_loader_if.slave wr,
  output logic              config_clk,
  output logic              config_reset,
  output logic              config_in,
  input  logic              config_out,
  output logic              busy,
  output logic              done,
  output logic              tail_bit
);
  localparam int NW  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int R   = CHAIN_LEN - WORD_W * (NW - 1);
  localparam int WCW = $clog2(NW + 1);
  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int RCW = $clog2(2 * RST_CYC + 1);
  localparam int SCW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, CRST, SHIFT, FIN} state_t;
  state_t state, state_nxt;

  logic [RCW-1:0]    rst_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [WORD_W-1:0] sreg, buf_dat, src_word, aligned;
  logic [SCW-1:0]    sreg_cnt;
  logic [WCW-1:0]    acc_cnt, ld_cnt;
  logic              buf_full, drv;
  logic              accept, bit_avail, last_rst, last_bit, rise, fetch, use_src, last_word, next_bit;
  logic              config_clk_nxt, config_reset_nxt, config_in_nxt, drv_nxt, tail_nxt;

  assign wr.word_ready = (state == CRST || state == SHIFT) && !buf_full && (acc_cnt < WCW'(NW));
  assign accept    = wr.word_valid && wr.word_ready;
  assign src_word  = buf_full ? buf_dat : wr.word_data;
  assign bit_avail = (sreg_cnt != '0) || buf_full || accept;
  assign last_rst  = (state == CRST) && (rst_cnt == RCW'(2 * RST_CYC - 1));
  assign last_bit  = (state == SHIFT) && config_clk && (bit_cnt == BCW'(CHAIN_LEN - 1));
  // drv marks a low cycle that already presents a bit; the next cycle raises config_clk
  assign rise      = (state == SHIFT) && !config_clk && drv;
  assign fetch     = bit_avail && (last_rst || ((state == SHIFT) && (config_clk ? !last_bit : !drv)));
  assign use_src   = fetch && (sreg_cnt == '0);
  assign last_word = (ld_cnt == WCW'(NW - 1));
  assign aligned   = last_word ? (src_word << (WORD_W - R)) : src_word;
  assign next_bit  = use_src ? aligned[WORD_W-1] : sreg[WORD_W-1];
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      config_clk   <= 1'b0;
      config_reset <= 1'b0;
      config_in    <= 1'b0;
      drv          <= 1'b0;
      tail_bit     <= 1'b0;
    end else begin
      state        <= state_nxt;
      config_clk   <= config_clk_nxt;
      config_reset <= config_reset_nxt;
      config_in    <= config_in_nxt;
      drv          <= drv_nxt;
      tail_bit     <= tail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CRST;
      CRST:    if (last_rst) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    config_clk_nxt   = rise;
    config_reset_nxt = (state_nxt == CRST);
    drv_nxt          = fetch || rise;
    config_in_nxt    = 1'b0;
    if (fetch)
      config_in_nxt = next_bit;
    else if (state == SHIFT && !last_bit)
      config_in_nxt = config_in;
    // tail is taken on the edge that raises config_clk, i.e. before the chain shifts
    tail_nxt = rise ? config_out : tail_bit;
  end

  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      rst_cnt  <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      sreg_cnt <= '0;
      buf_dat  <= '0;
      buf_full <= 1'b0;
      acc_cnt  <= '0;
      ld_cnt   <= '0;
    end else begin
      if (state == CRST) rst_cnt <= rst_cnt + 1'b1;
      if (state == SHIFT && config_clk) bit_cnt <= bit_cnt + 1'b1;
      if (use_src) begin
        sreg     <= aligned << 1;
        sreg_cnt <= last_word ? SCW'(R - 1) : SCW'(WORD_W - 1);
        ld_cnt   <= ld_cnt + 1'b1;
      end else if (fetch) begin
        sreg     <= sreg << 1;
        sreg_cnt <= sreg_cnt - 1'b1;
      end
      // a word arriving while the shift register is starved bypasses the buffer
      if (use_src && buf_full) begin
        buf_full <= 1'b0;
      end else if (accept && !use_src) begin
        buf_full <= 1'b1;
        buf_dat  <= wr.word_data;
      end
      if (accept) acc_cnt <= acc_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: 40-bit chain with a mock shift chain on config_out, plus a 32-bit single-word instance.
module tb_cfg_chain_loader;
  localparam int LEN = 40, WW = 32, RC = 2, NW = 2;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0;
  logic config_clk, config_reset, config_in, config_out, busy, done, tail_bit;
  logic c2_clk, c2_rst, c2_in, c2_busy, c2_done, c2_tail;
  logic c2_out = 1'b0;
  logic [LEN-1:0] chain = '0;

  cfg_chain_loader_if #(.WORD_W(WW)) wif();
  cfg_chain_loader_if #(.WORD_W(WW)) wif2();

  cfg_chain_loader #(.CHAIN_LEN(LEN), .WORD_W(WW), .RST_CYC(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .wr(wif),
    .config_clk(config_clk), .config_reset(config_reset), .config_in(config_in),
    .config_out(config_out), .busy(busy), .done(done), .tail_bit(tail_bit));

  cfg_chain_loader #(.CHAIN_LEN(32), .WORD_W(WW), .RST_CYC(RC)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .wr(wif2),
    .config_clk(c2_clk), .config_reset(c2_rst), .config_in(c2_in),
    .config_out(c2_out), .busy(c2_busy), .done(c2_done), .tail_bit(c2_tail));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mock daisy chain: head at bit 0, tail at bit LEN-1, no reset
  always @(posedge config_clk) chain <= {chain[LEN-2:0], config_in};
  assign config_out = chain[LEN-1];

  int checks = 0, failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // model state for the current load
  bit exp_q[$], prev_q[$], last_q[$];
  logic [WW-1:0] fq_dat[$];
  int fq_at[$];
  bit m_active = 1'b0, m_tail = 1'b0;
  int m_t0 = 0, m_done_at = 0, m_idx = 0, m_acc = 0, done_seen = -1;
  logic [LEN-1:0] got_bits = '0, got_tail = '0;

  initial begin : feeder
    logic fire;
    wif.word_valid = 1'b0;
    wif.word_data  = '0;
    forever begin
      @(negedge clk);
      fire = wif.word_valid && wif.word_ready;
      @(posedge clk);
      #1;
      if (fire && fq_dat.size() > 0) begin
        void'(fq_dat.pop_front());
        void'(fq_at.pop_front());
      end
      if (fq_dat.size() > 0 && cyc >= fq_at[0]) begin
        wif.word_valid = 1'b1;
        wif.word_data  = fq_dat[0];
      end else begin
        wif.word_valid = 1'b0;
      end
    end
  end

  initial begin : compare
    logic prev_clk, prev_in;
    int c;
    prev_clk = 1'b0;
    prev_in  = 1'b0;
    forever begin
      @(negedge clk);
      if (m_active) begin
        c = cyc;
        chk1("config_reset", config_reset, (c >= m_t0 + 1) && (c <= m_t0 + 2 * RC));
        chk1("busy", busy, (c >= m_t0 + 1) && (c <= m_done_at));
        chk1("done", done, c == m_done_at);
        if (done) done_seen = c;
        if (config_clk && !prev_clk) begin
          chk1("edge_within_len", m_idx < LEN, 1'b1);
          chk1("in_stable_at_rise", config_in, prev_in);
          if (m_idx < LEN) begin
            chk1("bit_in", config_in, exp_q[m_idx]);
            got_bits[LEN-1-m_idx] = config_in;
            got_tail[LEN-1-m_idx] = tail_bit;
            if (m_tail) chk1("tail_bit", tail_bit, prev_q[m_idx]);
          end
          m_idx++;
        end
        if (c == m_done_at) begin
          chkv("edges_at_done", 64'(m_idx), 64'(LEN));
          chkv("fin_clk_in", 64'({config_clk, config_in}), 64'(0));
        end
        if (m_acc >= NW) chk1("ready_after_last", wif.word_ready, 1'b0);
        if (wif.word_valid && wif.word_ready) m_acc++;
        if (c == m_done_at + 1) m_active = 1'b0;
      end
      prev_clk = config_clk;
      prev_in  = config_in;
    end
  end

  // call at posedge+#1; w1_at is the cycle offset from start at which word 1 is first offered
  task automatic run_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                          input int w1_at, input int stall, input bit tail_chk);
    exp_q.delete();
    for (int b = WW - 1; b >= 0; b--) exp_q.push_back(w0[b]);
    for (int b = LEN - WW - 1; b >= 0; b--) exp_q.push_back(w1[b]);
    prev_q = last_q;
    m_tail = tail_chk;
    fq_dat.push_back(w0); fq_at.push_back(cyc);
    fq_dat.push_back(w1); fq_at.push_back(cyc + w1_at);
    m_t0 = cyc;
    m_done_at = cyc + 1 + 2 * (RC + LEN) + stall;
    m_idx = 0; m_acc = 0; done_seen = -1;
    got_bits = '0; got_tail = '0;
    m_active = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_load();
    for (int i = 0; i < 400 && m_active; i++) @(posedge clk);
    chkv("load_timeout", 64'(m_active), 64'(0));
    m_active = 1'b0;
    #1;
    last_q = exp_q;
  endtask

  logic [31:0] b2;
  logic p2;
  int t2, e2, d2, a2;

  initial begin : main
    wif2.word_valid = 1'b0;
    wif2.word_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chkv("reset_outputs", 64'({config_clk, config_reset, config_in, busy, done, wif.word_ready, tail_bit}), 64'(0));
    @(posedge clk); #1;

    // plain load, words always valid
    run_load(32'hA5A5A5A5, 32'h000000C3, 0, 0, 1'b0);
    wait_load();
    chkv("t1_bits", 64'(got_bits), 64'hA5A5A5A5C3);
    chkv("t1_done_latency", 64'(done_seen - m_t0), 64'd85);
    chkv("t1_accepts", 64'(m_acc), 64'd2);
    repeat (3) @(posedge clk); #1;

    // second word withheld until 6 cycles after it is needed
    run_load(32'hA5A5A5A5, 32'h000000C3, 74, 6, 1'b0);
    wait_load();
    chkv("t2_bits", 64'(got_bits), 64'hA5A5A5A5C3);
    chkv("t2_done_latency", 64'(done_seen - m_t0), 64'd91);
    repeat (3) @(posedge clk); #1;

    // zeros load: the tail replays the previous bitstream
    run_load(32'h0, 32'h0, 0, 0, 1'b1);
    wait_load();
    chkv("t3_tail_stream", 64'(got_tail), 64'hA5A5A5A5C3);
    repeat (3) @(posedge clk); #1;

    // start re-pulsed mid-shift
    run_load(32'hA5A5A5A5, 32'h000000C3, 0, 0, 1'b1);
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_load();
    chkv("t4_done_latency", 64'(done_seen - m_t0), 64'd85);
    repeat (3) @(posedge clk); #1;

    // reset at bit 17, then a full reload
    run_load(32'hA5A5A5A5, 32'h000000C3, 0, 0, 1'b0);
    for (int i = 0; i < 200 && m_idx < 17; i++) @(negedge clk);
    chkv("t5_reached_bit17", 64'(m_idx), 64'd17);
    @(posedge clk); #1;
    m_active = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    fq_dat.delete(); fq_at.delete();
    @(negedge clk);
    chkv("t5_reset_outputs", 64'({config_clk, config_reset, config_in, busy, done, wif.word_ready, tail_bit}), 64'(0));
    @(posedge clk); #1;
    run_load(32'hA5A5A5A5, 32'h000000C3, 0, 0, 1'b0);
    wait_load();
    chkv("t5_reload_bits", 64'(got_bits), 64'hA5A5A5A5C3);
    chkv("t5_reload_latency", 64'(done_seen - m_t0), 64'd85);

    // 32-bit chain, one exact word
    wif2.word_data  = 32'h80000001;
    wif2.word_valid = 1'b1;
    t2 = cyc;
    start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    p2 = 1'b0; b2 = '0; e2 = 0; d2 = -1; a2 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (c2_clk && !p2) begin
        b2 = {b2[30:0], c2_in};
        e2++;
      end
      p2 = c2_clk;
      if (c2_done && d2 < 0) d2 = cyc;
      if (wif2.word_valid && wif2.word_ready) a2++;
    end
    chkv("t6_bits", 64'(b2), 64'h80000001);
    chkv("t6_edges", 64'(e2), 64'd32);
    chkv("t6_done_latency", 64'(d2 - t2), 64'd69);
    chkv("t6_accepts", 64'(a2), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
Serial configuration loader that drives the config_clk/config_reset/config_in daisy chain threading every BlockPE-class cell in an array column. It accepts bitstream words over a valid/ready interface, asserts a chain reset, then shifts exactly CHAIN_LEN bits into the chain with a generated config_clk. It sits directly upstream of the first cell's config_in, and monitors the tail config_out for a loopback check.

Parameters:
CHAIN_LEN, 64, total config bits in the chain (≥1)
WORD_W, 32, bitstream word width
RST_CYC, 2, config_clk periods config_reset is held high

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous active-high reset
start  input  1  one-cycle load request; ignored unless IDLE
word_valid  input  1  bitstream word available
word_data  input  WORD_W  bitstream word
word_ready  output  1  loader accepts word this cycle
config_clk  output  1  generated chain clock, registered
config_reset  output  1  chain reset, registered
config_in  output  1  serial bit into chain head, registered
config_out  input  1  chain tail bit (loopback)
busy  output  1  high in any state but IDLE
done  output  1  one-cycle pulse at load completion
tail_bit  output  1  config_out captured at each config_clk rising edge

Behaviour:
- Reset (sync): state=IDLE; config_clk, config_reset, config_in, busy, done, word_ready, tail_bit = 0; shift reg and holding buffer empty; counters 0. Reset mid-load aborts at next edge; chain contents then undefined.
- States: IDLE -> CRST -> SHIFT -> FIN -> IDLE.
- IDLE: start=1 -> CRST next cycle. start while busy ignored.
- config_clk timing: each chain period = 2 clk cycles; phase 0 config_clk=0 (config_in/config_reset update), phase 1 config_clk=1 (chain captures on rising edge). config_in never changes in the same cycle config_clk rises.
- CRST: config_reset=1, config_in=0, RST_CYC full periods; then config_reset=0, go SHIFT.
- Word buffering: 1-entry holding buffer + WORD_W shift register. word_ready=1 in CRST or SHIFT whenever holding buffer empty and words still owed; transfer on word_valid&&word_ready. Words owed total NW=ceil(CHAIN_LEN/WORD_W); word_ready never asserted after NW accepted.
- Bit order: words in arrival order, each MSB first. Last word uses only bits [R-1:0], R=CHAIN_LEN-WORD_W*(NW-1), shifted from bit R-1; its upper bits ignored.
- SHIFT: at phase 0, if a bit is available (shift reg non-empty, or buffer loads it this cycle) drive config_in, proceed to phase 1; else stall with config_clk=0, no edge emitted. Bit counter increments per phase 1; after bit CHAIN_LEN-1's phase 1 -> FIN.
- FIN: config_clk=0, config_in=0, done=1 for exactly one cycle, busy=0 next cycle, -> IDLE.
- Latency, no stalls, start seen at cycle T: config_reset high cycles T+1..T+2*RST_CYC; first config_clk rise at T+2*RST_CYC+2; done at T+1+2*(RST_CYC+CHAIN_LEN).
- tail_bit: sampled config_out in each phase-1 cycle; holds otherwise.
- Exactly CHAIN_LEN rising config_clk edges after config_reset falls; never more, even if extra words offered.

Test Plan:
- CHAIN_LEN=40, RST_CYC=2, words 0xA5A5A5A5, 0x000000C3 always valid, start at T -> config_in sampled at rising edges = 10100101 x4 then 11000011; 40 edges; done at T+85; word_ready low after 2nd accept.
- Same, word_valid low 6 cycles before 2nd word -> config_clk held low, no edges during gap, bit sequence unchanged, done 6 cycles later (T+91).
- Mock 40-bit shift chain looped to config_out, load, then second load of zeros -> tail_bit over second load reproduces first bitstream in order.
- start pulsed again mid-SHIFT -> ignored; exactly 40 edges, one done pulse.
- reset asserted at bit 17 -> next cycle all outputs 0, IDLE; new start reloads fully with config_reset pulse first.
- CHAIN_LEN=32 exact word: one word 0x80000001 -> NW=1, first and last bits 1, 30 zeros, done at T+69.
